mem_port_arbiter: RTL and testbench

- Shares the single-ported unified memory between the instruction-fetch (IF) requester and the load/store (D) requester.
- Sequences one memory transaction at a time. Counts the fixed memory latency and returns a one-cycle ready pulse to the winning requester.
- Drives `sel` to the 2:1 address/data mux in front of the memory: 0 = IF path, 1 = D path.
- Sits between the fetch stage, the MEM stage and the memory macro.

---
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and load/store.
// Optional macro ROUND_ROBIN_EN: ties go to the side not granted last (default: D wins ties).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              sel,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [CNT_W-1:0] LAT_END = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] LAT_PRE = CNT_W'(MEM_LAT - 1);

  logic [0:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sel_nxt;
  logic             mem_en_nxt;
  logic             if_ready_nxt;
  logic             d_ready_nxt;
  logic             grant_d;

`ifdef ROUND_ROBIN_EN
  logic last_d, last_d_nxt;

  // On a tie the side that did not win last time takes the memory.
  always_comb grant_d = d_req & (~if_req | ~last_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_d <= 1'b1;
    else      last_d <= last_d_nxt;
  end
`else
  always_comb grant_d = d_req;
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    sel_nxt      = sel;
    mem_en_nxt   = 1'b0;
    if_ready_nxt = 1'b0;
    d_ready_nxt  = 1'b0;
`ifdef ROUND_ROBIN_EN
    last_d_nxt   = last_d;
`endif
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          state_nxt  = BUSY;
          cnt_nxt    = '0;
          sel_nxt    = grant_d;
          mem_en_nxt = 1'b1;
`ifdef ROUND_ROBIN_EN
          last_d_nxt = grant_d;
`endif
        end
      end
      BUSY: begin
        if (cnt == LAT_END) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          // Ready is a flop, so it is armed one count early to land on LAT_END.
          if (cnt == LAT_PRE) begin
            if_ready_nxt = ~sel;
            d_ready_nxt  = sel;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sel      <= 1'b0;
      mem_en   <= 1'b0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      sel      <= sel_nxt;
      mem_en   <= mem_en_nxt;
      if_ready <= if_ready_nxt;
      d_ready  <= d_ready_nxt;
    end
  end

  // Datapath mux and read-data fan-out.
  assign mem_we    = mem_en & sel & d_we;
  assign mem_addr  = sel ? d_addr : if_addr;
  assign mem_wdata = d_wdata;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-schedule reference model.
module tb_mem_port_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ready;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ready;
  logic [DW-1:0] d_rdata;
  logic          sel;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .sel(sel), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference model: a granted transaction is a schedule of absolute cycle numbers.
  int idle_cyc, issue_cyc, rdy_cyc;
  bit side, m_sel, last_d, if_pend, d_pend, w;
  int n_rst;

  task automatic model_reset();
    idle_cyc  = cyc;
    issue_cyc = -10;
    rdy_cyc   = -10;
    m_sel     = 1'b0;
    last_d    = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_en"}, 64'(mem_en), 64'(0));
    chk({tag, "_mem_we"}, 64'(mem_we), 64'(0));
    chk({tag, "_if_ready"}, 64'(if_ready), 64'(0));
    chk({tag, "_d_ready"}, 64'(d_ready), 64'(0));
    chk({tag, "_sel"}, 64'(sel), 64'(0));
  endtask

  initial begin
    if_pend = 1'b0;
    d_pend  = 1'b0;
    side    = 1'b0;
    n_rst   = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    cyc = 0;
    model_reset();

    for (int it = 0; it < 3000; it++) begin
      // Drive stimulus for the next rising edge.
      if (!if_pend && !(side == 1'b0 && cyc < rdy_cyc) && ($urandom % 3 == 0)) begin
        if_pend = 1'b1;
        if_addr = $urandom;
      end
      if (!d_pend && !(side == 1'b1 && cyc < rdy_cyc) && ($urandom % 3 == 0)) begin
        d_pend  = 1'b1;
        d_we    = 1'($urandom % 2);
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      if_req    = if_pend;
      d_req     = d_pend;
      mem_rdata = $urandom;

      if (cyc >= idle_cyc && (if_pend || d_pend)) begin
`ifdef ROUND_ROBIN_EN
        w = (if_pend && d_pend) ? ~last_d : d_pend;
`else
        w = d_pend;
`endif
        side      = w;
        last_d    = w;
        issue_cyc = cyc + 1;
        rdy_cyc   = cyc + 1 + LAT;
        idle_cyc  = cyc + LAT + 2;
      end

      @(posedge clk);
      cyc++;
      @(negedge clk);

      if (cyc == issue_cyc) m_sel = side;
      chk("sel", 64'(sel), 64'(m_sel));
      chk("mem_en", 64'(mem_en), 64'(cyc == issue_cyc));
      chk("mem_we", 64'(mem_we), 64'((cyc == issue_cyc) && side && d_we));
      chk("mem_addr", 64'(mem_addr), 64'(m_sel ? d_addr : if_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(d_wdata));
      chk("if_ready", 64'(if_ready), 64'((cyc == rdy_cyc) && !side));
      chk("d_ready", 64'(d_ready), 64'((cyc == rdy_cyc) && side));
      if (cyc == rdy_cyc && !side) chk("if_rdata", 64'(if_rdata), 64'(mem_rdata));
      if (cyc == rdy_cyc && side && !d_we) chk("d_rdata", 64'(d_rdata), 64'(mem_rdata));

      if (cyc == rdy_cyc) begin
        if (side) d_pend = 1'b0;
        else      if_pend = 1'b0;
      end else if (cyc >= issue_cyc && cyc < rdy_cyc) begin
        // Granted side may move its address or drop its request once issued.
        if ($urandom % 2 == 0) begin
          if (side) d_addr = $urandom;
          else      if_addr = $urandom;
        end
        if ($urandom % 10 == 0) begin
          if (side) d_pend = 1'b0;
          else      if_pend = 1'b0;
        end
      end

      // Occasional reset in the cycle after an issue: the transaction must vanish.
      if (cyc == issue_cyc && it > 100 && n_rst < 8 && ($urandom % 8 == 0)) begin
        n_rst++;
        if_req = if_pend;
        d_req  = d_pend;
        @(posedge clk);
        cyc++;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        cyc++;
        #1;
        check_reset_outputs("inrst");
        @(negedge clk);
        rst = 1'b1;
        model_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
